serial_adder_nbit: RTL and testbench
====================================

# serial_adder_nbit

Parametrised multi-cycle two's-complement adder/subtractor, successor to the 4-bit ripple adder. It processes a WIDTH-bit operand pair CHUNK bits per cycle, LSB chunk first, and carries between chunks in a register. It reports sum, carryout and signed overflow with the same meaning as the 4-bit adder. It sits between an operand source and a result sink, with valid/ready handshakes on both sides.

## Interface
- WIDTH, default 16: operand and result width; must be ≥ 2.
- CHUNK, default 4: bits added per cycle; must be ≥ 1 and divide WIDTH exactly. NCHUNK = WIDTH/CHUNK.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result available.
- out_ready  in  1  sink accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- carryout  out  1  carry out of bit WIDTH−1.
- overflow  out  1  signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE: in_ready=1. Accept occurs on an edge with in_valid=1. On accept:
  - latch A;
  - latch B' = sub ? ~b : b;
  - carry register = sub;
  - chunk counter = 0;
  - go to RUN.
- RUN: in_ready=0. Each cycle, add chunk i of A, chunk i of B' and the carry register, then:
  - write the CHUNK result bits to sum chunk i;
  - update the carry register;
  - increment the counter.
- Leaving RUN: after chunk NCHUNK−1 is processed, go to DONE.
  - carryout = final carry.
  - overflow = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]).
- Subtraction computes A + ~B + 1. carryout is the raw carry, so 1 means no borrow (e.g. 4−4 gives co=1).
- DONE: out_valid=1, in_ready=0. sum, carryout and overflow are held stable. Leave to IDLE on an edge with out_ready=1.
- Operand inputs are ignored outside IDLE. Operands are not re-sampled during RUN, so a, b and sub may change freely after accept.
- No overlap: a new accept is possible only in the cycle after the result handshake.
- sum, carryout and overflow keep their last value in IDLE and RUN until overwritten. They are meaningful only while out_valid=1.
- rst_n low at any time, including mid-RUN or in DONE, has these effects immediately:
  - state = IDLE, in_ready = 1;
  - out_valid = 0, sum = 0, carryout = 0, overflow = 0;
  - carry register = 0, counter = 0.
  - The partial result is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, sum=0, carryout=0, overflow=0.
- Accept at edge t0 leads to RUN on cycles t0..t0+NCHUNK−1. out_valid rises after edge t0+NCHUNK. Latency is NCHUNK cycles.
- Result handshake at edge t1: out_valid=0 and in_ready=1 after t1. The earliest next accept is at edge t1+1.
- Throughput is one operation per NCHUNK+2 cycles with the sink always ready.
- CHUNK=WIDTH gives a latency of 1 cycle (single RUN cycle).
- in_ready and out_valid are registered state decodes, never combinational from inputs.

## Test plan
- WIDTH=4, CHUNK=1: add 0100+0100 -> sum=1000, co=0, ov=1, out_valid 4 cycles after accept. Add 1000+1000 -> 0000, co=1, ov=1. Add 0110+1111 -> 0101, co=1, ov=0.
- WIDTH=4, CHUNK=2, sub: 0011−0101 -> 1110, co=0, ov=0. Then 0100−0100 -> 0000, co=1, ov=0.
- WIDTH=16, CHUNK=4: 0x7FFF+0x0001 -> 0x8000, co=0, ov=1, latency 4. Sub 0x8000−0x0001 -> 0x7FFF, co=1, ov=1.
- Backpressure, WIDTH=16, CHUNK=4: hold out_ready=0 for 5 cycles in DONE while toggling in_valid, a and b -> outputs stable, in_ready=0, no new accept. Raise out_ready -> IDLE next cycle.
- Reset mid-op: assert rst_n=0 asynchronously in RUN cycle 2 of 4 -> all outputs at reset values immediately. The next operation 0x1234+0x1111 -> 0x2345, co=0, ov=0, with a correct 4-cycle latency.
- Exhaustive sweep at WIDTH=4, CHUNK=1 and WIDTH=4, CHUNK=4: all 512 (a, b, sub) combinations -> sum, co and ov match a reference model of A + (sub ? ~B : B) + sub.

Source files
------------

// File: rtl/serial_adder_nbit_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_nbit_if
// Purpose  : Operand/result valid-ready bundle for the chunked serial adder.
// Revision : 1.0
// ============================================================================
interface serial_adder_nbit_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, carryout, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, carryout, overflow
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder_nbit.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_nbit
// Purpose  : Multi-cycle two's-complement add/sub, CHUNK bits per cycle, LSB first.
// Revision : 1.0
// ============================================================================
module serial_adder_nbit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    serial_adder_nbit_if.slave bus
);
    localparam int C_NCHUNK = WIDTH / CHUNK;
    localparam int C_CNT_W  = (C_NCHUNK > 1) ? $clog2(C_NCHUNK) : 1;
    localparam int C_RES_W  = CHUNK + 1;
    localparam logic [WIDTH-1:0]   C_CHUNK_MASK = WIDTH'({CHUNK{1'b1}});
    localparam logic [C_CNT_W-1:0] C_LAST       = C_CNT_W'(C_NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic                carry_q, carry_d;
    logic [C_CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]    sum_q, sum_d;
    logic                carryout_q, carryout_d;
    logic                overflow_q, overflow_d;

    logic [31:0]         w_base;
    logic [CHUNK-1:0]    w_a_chunk;
    logic [CHUNK-1:0]    w_b_chunk;
    logic [C_RES_W-1:0]  w_chunk_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            sum_q      <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            carryout_q <= carryout_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        carryout_d  = carryout_q;
        overflow_d  = overflow_q;

        // Chunk i is selected by shifting rather than an indexed part-select.
        w_base      = 32'(cnt_q) * 32'(CHUNK);
        w_a_chunk   = CHUNK'(a_q >> w_base);
        w_b_chunk   = CHUNK'(b_q >> w_base);
        w_chunk_res = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + C_RES_W'(carry_q);

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d   = (sum_q & ~(C_CHUNK_MASK << w_base))
                        | (WIDTH'(w_chunk_res[CHUNK-1:0]) << w_base);
                carry_d = w_chunk_res[CHUNK];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == C_LAST) begin
                    cnt_d      = '0;
                    carryout_d = w_chunk_res[CHUNK];
                    overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.sum       = sum_q;
    assign bus.carryout  = carryout_q;
    assign bus.overflow  = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_serial_adder_nbit.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder_nbit
// Purpose  : Self-checking bench for serial_adder_nbit over four WIDTH/CHUNK configurations.
// Revision : 1.0
// ============================================================================
module tb_serial_adder_nbit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Index 0: W4/C1, 1: W4/C2, 2: W4/C4, 3: W16/C4
    int cfg_w [4] = '{4, 4, 4, 16};
    int cfg_n [4] = '{4, 2, 1, 4};

    logic        in_valid_v  [4];
    logic [15:0] a_v         [4];
    logic [15:0] b_v         [4];
    logic        sub_v       [4];
    logic        out_ready_v [4];
    logic        in_ready_v  [4];
    logic        out_valid_v [4];
    logic [15:0] sum_v       [4];
    logic        co_v        [4];
    logic        ov_v        [4];

    for (genvar i = 0; i < 4; i++) begin : g_dut
        localparam int W = (i == 3) ? 16 : 4;
        localparam int C = (i == 0) ? 1 : (i == 1) ? 2 : 4;
        serial_adder_nbit_if #(.WIDTH(W)) ifc ();
        serial_adder_nbit #(.WIDTH(W), .CHUNK(C)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ifc)
        );
        assign ifc.in_valid   = in_valid_v[i];
        assign ifc.a          = a_v[i][W-1:0];
        assign ifc.b          = b_v[i][W-1:0];
        assign ifc.sub        = sub_v[i];
        assign ifc.out_ready  = out_ready_v[i];
        assign in_ready_v[i]  = ifc.in_ready;
        assign out_valid_v[i] = ifc.out_valid;
        assign sum_v[i]       = 16'(ifc.sum);
        assign co_v[i]        = ifc.carryout;
        assign ov_v[i]        = ifc.overflow;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed/unsigned arithmetic on integers, independent of chunking.
    task automatic model(input int w, input logic [15:0] av, input logic [15:0] bv, input logic s,
                         output logic [15:0] es, output logic eco, output logic eov);
        longint ua, ub, md, sa, sb, r, u;
        md = longint'(1) << w;
        ua = longint'(av);
        ub = longint'(bv);
        sa = (ua >= md / 2) ? ua - md : ua;
        sb = (ub >= md / 2) ? ub - md : ub;
        r  = s ? sa - sb : sa + sb;
        eov = (r > md / 2 - 1) || (r < -(md / 2));
        eco = s ? (ua >= ub) : (ua + ub >= md);
        u   = s ? ua - ub : ua + ub;
        u   = ((u % md) + md) % md;
        es  = 16'(u);
    endtask

    task automatic do_op(int d, logic [15:0] av_in, logic [15:0] bv_in, logic s, int hold);
        logic [15:0] m, av, bv, es;
        logic        eco, eov;
        int          k;
        m  = (cfg_w[d] == 16) ? 16'hFFFF : 16'((1 << cfg_w[d]) - 1);
        av = av_in & m;
        bv = bv_in & m;
        model(cfg_w[d], av, bv, s, es, eco, eov);
        chk("idle_ready", 32'(in_ready_v[d]), 32'd1);
        in_valid_v[d] = 1'b1;
        a_v[d]        = av;
        b_v[d]        = bv;
        sub_v[d]      = s;
        @(negedge clk);
        k = 0;
        while (out_valid_v[d] !== 1'b1 && k < 40) begin
            in_valid_v[d] = 1'($urandom);
            a_v[d]        = 16'($urandom);
            b_v[d]        = 16'($urandom);
            sub_v[d]      = 1'($urandom);
            @(negedge clk);
            k++;
        end
        in_valid_v[d] = 1'b0;
        chk("latency", 32'(k), 32'(cfg_n[d]));
        chk("done_ready", 32'(in_ready_v[d]), 32'd0);
        chk("sum", 32'(sum_v[d]), 32'(es));
        chk("carryout", 32'(co_v[d]), 32'(eco));
        chk("overflow", 32'(ov_v[d]), 32'(eov));
        for (int i = 0; i < hold; i++) begin
            in_valid_v[d] = 1'($urandom);
            a_v[d]        = 16'($urandom);
            b_v[d]        = 16'($urandom);
            sub_v[d]      = 1'($urandom);
            @(negedge clk);
            chk("hold_valid", 32'(out_valid_v[d]), 32'd1);
            chk("hold_ready", 32'(in_ready_v[d]), 32'd0);
            chk("hold_sum", 32'(sum_v[d]), 32'(es));
            chk("hold_co", 32'(co_v[d]), 32'(eco));
            chk("hold_ov", 32'(ov_v[d]), 32'(eov));
        end
        in_valid_v[d]  = 1'b0;
        out_ready_v[d] = 1'b1;
        @(negedge clk);
        out_ready_v[d] = 1'b0;
        chk("post_valid", 32'(out_valid_v[d]), 32'd0);
        chk("post_ready", 32'(in_ready_v[d]), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            in_valid_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0; sub_v[i] = 1'b0; out_ready_v[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_ready", 32'(in_ready_v[i]), 32'd1);
            chk("rst_valid", 32'(out_valid_v[i]), 32'd0);
            chk("rst_sum", 32'(sum_v[i]), 32'd0);
            chk("rst_co", 32'(co_v[i]), 32'd0);
            chk("rst_ov", 32'(ov_v[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases from the plan
        do_op(0, 16'h4, 16'h4, 1'b0, 0);
        do_op(0, 16'h8, 16'h8, 1'b0, 0);
        do_op(0, 16'h6, 16'hF, 1'b0, 0);
        do_op(1, 16'h3, 16'h5, 1'b1, 0);
        do_op(1, 16'h4, 16'h4, 1'b1, 0);
        do_op(3, 16'h7FFF, 16'h0001, 1'b0, 0);
        do_op(3, 16'h8000, 16'h0001, 1'b1, 0);
        do_op(3, 16'h8000, 16'h0001, 1'b1, 5);

        // Asynchronous reset in the second RUN cycle, away from any clock edge
        in_valid_v[3] = 1'b1; a_v[3] = 16'hABCD; b_v[3] = 16'h1357; sub_v[3] = 1'b0;
        @(negedge clk);
        in_valid_v[3] = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(in_ready_v[3]), 32'd1);
        chk("mid_rst_valid", 32'(out_valid_v[3]), 32'd0);
        chk("mid_rst_sum", 32'(sum_v[3]), 32'd0);
        chk("mid_rst_co", 32'(co_v[3]), 32'd0);
        chk("mid_rst_ov", 32'(ov_v[3]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(3, 16'h1234, 16'h1111, 1'b0, 0);

        // Exhaustive sweep at W4/C1 and W4/C4
        foreach (cfg_n[d]) begin
            if (d == 0 || d == 2) begin
                for (int s = 0; s < 2; s++)
                    for (int x = 0; x < 16; x++)
                        for (int y = 0; y < 16; y++)
                            do_op(d, 16'(x), 16'(y), 1'(s), 0);
            end
        end

        // Random operands with occasional backpressure
        for (int i = 0; i < 150; i++) begin
            do_op(1, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
            do_op(3, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
